array_divider8x4: RTL and testbench
===================================

# array_divider8x4

Sequential restoring divider, the inverse of the 4x4 array multiplier. It takes an 8-bit product-width dividend P and a 4-bit divisor B, and returns quotient Q and remainder R, so that P = Q*B + R. It runs one quotient bit per clock under a start/busy/done handshake. It recovers a multiplier operand from a product and checks multiplier results in self-checking benches.

## Interface
- PW, 8, dividend and quotient width; only the default is verified.
- BW, 4, divisor and remainder width; BW < PW required.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- P  input  PW  dividend; captured on the accepted start edge.
- B  input  BW  divisor; captured on the accepted start edge.
- Q  output  PW  quotient; registered.
- R  output  BW  remainder; registered.
- busy  output  1  high from the edge after acceptance until the edge that leaves DONE.
- done  output  1  one-cycle pulse; Q, R, dz, fit valid while high.
- dz  output  1  divide-by-zero flag for the current result.
- fit  output  1  Q < 2^BW, i.e. the result is a legal 4x4 multiplier operand.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1, B!=0:
  - Capture P into the shift register and B into the divisor register.
  - Clear the partial remainder (BW+1 bits) and set the bit counter to PW-1.
  - Go to CALC.
- IDLE, start=1, B==0:
  - Go directly to DONE with Q=8'hFF, R=4'hF, dz=1, fit=0.
- IDLE, start=0: stay. Q, R, dz and fit hold their last values.
- CALC, each cycle:
  - Form t = {rem[BW-1:0], dividend MSB}.
  - If t >= divisor: rem = t - divisor and shift 1 into the quotient LSB. Otherwise rem = t and shift 0.
  - Shift the dividend left by 1.
  - At counter 0, go to DONE. Otherwise decrement the counter.
- Width rules:
  - Partial remainder is BW+1 bits; the compare and subtract are unsigned BW+1 bits.
  - Final remainder < B, so it fits in BW bits.
  - Quotient is a full PW bits; there is no overflow.
- DONE: done=1, busy=1 and Q/R/dz/fit are valid. Next edge goes unconditionally to IDLE.
- start is ignored in CALC and DONE; there is no queuing.
- P and B may change at any time after the accepting edge without affecting the result.
- Reset, asynchronous and at any time including mid-CALC:
  - State = IDLE.
  - Q=0, R=0, busy=0, done=0, dz=0, fit=0.
  - Internal registers = 0.
  - Any operation in flight is abandoned with no done pulse.
- After rst_n deasserts, the first start is accepted normally.

## Timing
- Accepting edge k (IDLE, start=1, B!=0):
  - busy=1 after edge k.
  - CALC on edges k+1..k+8.
  - DONE after edge k+8, so done=1 during cycle k+8..k+9.
  - IDLE after edge k+9.
- Latency: start to done = 9 cycles. Throughput is one result per 10 cycles, since start held high is re-accepted at edge k+10.
- Divide by zero: DONE after edge k, done=1 for one cycle, IDLE after edge k+1. Latency is 1 cycle.
- Q, R, dz and fit update only on the DONE entry edge or on reset. They stay stable between done pulses.
- done is never high for two consecutive cycles.

## Test plan
- Reset: hold rst_n=0, then release. Q=0, R=0, busy=0, done=0, dz=0 and fit=0 before the first edge.
- Inverse-of-multiplier vectors (P, B -> Q, R, fit):
  - 110, 10 -> 11, 0, 1
  - 15, 15 -> 1, 0, 1
  - 84, 7 -> 12, 0, 1
  - 150, 15 -> 10, 0, 1
  - Each: done exactly 9 cycles after the start edge.
- Non-product and wide quotient (P, B -> Q, R, fit):
  - 200, 7 -> 28, 4, 0
  - 255, 1 -> 255, 0, 0
  - 0, 9 -> 0, 0, 1
  - 14, 15 -> 0, 14, 1
- Divide by zero: P=100, B=0. done 1 cycle after start, Q=8'hFF, R=4'hF, dz=1, fit=0. The next start with P=110, B=10 clears dz: Q=11, dz=0.
- Handshake:
  - Pulse start with P=110, B=10, then pulse start with P=255, B=1 at cycles k+3 and k+8. Only one done occurs, with Q=11. The ignored operands never appear.
  - start held high for 25 cycles with P=200, B=7: done pulses at k+8 and k+18 only, each with Q=28, R=4.
- Reset mid-operation: assert rst_n=0 at cycle k+4 of P=200, B=7. Outputs go to 0 immediately and no done occurs. After release, P=84, B=7 gives Q=12, R=0 at +9 cycles.

Source files
------------

// File: rtl/array_divider8x4.sv
`default_nettype none
// ============================================================================
// Module      : array_divider8x4
// Description : Sequential restoring divider, P = Q*B + R. Resolves one
//               quotient bit per clock under a start/busy/done handshake.
//               Used to recover a 4x4 multiplier operand from a product.
// Revision    : 1.0 - initial release
// ============================================================================
module array_divider8x4 #(
  parameter int PW = 8,
  parameter int BW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] P,
  input  logic [BW-1:0] B,
  output logic [PW-1:0] Q,
  output logic [BW-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          fit
);

  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] C_CNT_INIT = CW'(PW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  // Dividend shift register; quotient bits enter at the LSB as the dividend
  // leaves at the MSB, so after PW steps it holds the quotient.
  logic [PW-1:0] sreg_q, sreg_d;
  logic [BW-1:0] div_q, div_d;
  // Partial remainder is always < divisor between steps, so BW bits suffice
  // for storage; the trial value and subtraction below are BW+1 bits.
  logic [BW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] q_q, q_d;
  logic [BW-1:0] r_q, r_d;
  logic          dz_q, dz_d;
  logic          fit_q, fit_d;

  logic [BW:0]   w_t;
  logic          w_ge;
  logic [BW-1:0] w_rem_next;
  logic [PW-1:0] w_quo_next;

  // One restoring step: bring down the next dividend bit, trial-subtract.
  always_comb begin
    w_t        = {rem_q, sreg_q[PW-1]};
    w_ge       = (w_t >= {1'b0, div_q});
    // When t >= divisor the difference is < divisor, so its low BW bits are exact.
    w_rem_next = w_ge ? (w_t[BW-1:0] - div_q) : w_t[BW-1:0];
    w_quo_next = {sreg_q[PW-2:0], w_ge};
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      fit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      fit_q   <= fit_d;
    end
  end

  // Next-state and datapath control; result registers change only on DONE entry.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    fit_d   = fit_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B == '0) begin
            // Divide by zero resolves immediately with a saturated result.
            q_d     = '1;
            r_d     = '1;
            dz_d    = 1'b1;
            fit_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            sreg_d  = P;
            div_d   = B;
            rem_d   = '0;
            cnt_d   = C_CNT_INIT;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        sreg_d = w_quo_next;
        rem_d  = w_rem_next;
        if (cnt_q == '0) begin
          q_d     = w_quo_next;
          r_d     = w_rem_next;
          dz_d    = 1'b0;
          fit_d   = (w_quo_next[PW-1:BW] == '0);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign dz   = dz_q;
  assign fit  = fit_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_array_divider8x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_divider8x4
// Description : Self-checking bench for array_divider8x4 against an
//               arithmetic reference model (P / B, P % B).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_array_divider8x4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] P;
  logic [3:0] B;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       dz;
  logic       fit;

  int checks;
  int errors;

  array_divider8x4 #(.PW(8), .BW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .P     (P),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .fit   (fit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the saturated divide-by-zero result.
  task automatic model(input int p, input int b, output int q, output int r,
                       output int edz, output int efit, output int lat);
    if (b == 0) begin
      q = 255; r = 15; edz = 1; efit = 0; lat = 1;
    end else begin
      q = p / b; r = p % b; edz = 0; efit = (q < 16) ? 1 : 0; lat = 9;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " Q"},    int'(Q),    0);
    check({tag, " R"},    int'(R),    0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " dz"},   int'(dz),   0);
    check({tag, " fit"},  int'(fit),  0);
  endtask

  // One full operation from IDLE: latency, result, then done/busy release.
  task automatic do_op(input int p, input int b, input string tag);
    int eq, er, edz, efit, elat, n;
    model(p, b, eq, er, edz, efit, elat);
    P = 8'(p); B = 4'(b); start = 1'b1;
    n = 0;
    do begin
      step();
      start = 1'b0;
      P = 8'($urandom);
      B = 4'($urandom);
      n++;
    end while (!done && n < 30);
    check({tag, " latency"}, n, elat);
    check({tag, " Q"},   int'(Q),   eq);
    check({tag, " R"},   int'(R),   er);
    check({tag, " dz"},  int'(dz),  edz);
    check({tag, " fit"}, int'(fit), efit);
    step();
    check({tag, " done drop"}, int'(done), 0);
    check({tag, " busy drop"}, int'(busy), 0);
    check({tag, " Q hold"},    int'(Q),    eq);
  endtask

  int dcount;
  int dpos[$];

  initial begin
    checks = 0; errors = 0;
    start = 1'b0; P = '0; B = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_zero("reset asserted");
    step(); step();
    #2 rst_n = 1'b1;
    check_zero("reset released");

    // Inverse-of-multiplier vectors.
    do_op(110, 10, "mul 110/10");
    do_op(15, 15,  "mul 15/15");
    do_op(84, 7,   "mul 84/7");
    do_op(150, 15, "mul 150/15");

    // Non-product and wide quotient.
    do_op(200, 7, "np 200/7");
    do_op(255, 1, "np 255/1");
    do_op(0, 9,   "np 0/9");
    do_op(14, 15, "np 14/15");

    // Divide by zero, then a normal op clears dz.
    do_op(100, 0, "dz 100/0");
    do_op(110, 10, "after dz 110/10");

    // Ignored starts during CALC and DONE.
    P = 8'd110; B = 4'd10; start = 1'b1;
    step();                                   // edge k
    start = 1'b0;
    dcount = 0;
    for (int e = 1; e <= 22; e++) begin
      if (e == 3 || e == 8) begin
        P = 8'd255; B = 4'd1; start = 1'b1;
      end
      step();                                 // edge k+e
      start = 1'b0;
      if (done) begin
        dcount++;
        check("hs ignored done pos", e, 8);
        check("hs ignored Q", int'(Q), 11);
        check("hs ignored R", int'(R), 0);
      end
    end
    check("hs ignored done count", dcount, 1);
    check("hs ignored Q final", int'(Q), 11);

    // start held high for 25 cycles.
    P = 8'd200; B = 4'd7; start = 1'b1;
    dpos.delete();
    for (int e = 0; e < 25; e++) begin
      step();                                 // edge k+e
      if (done) begin
        dpos.push_back(e);
        check("held Q", int'(Q), 28);
        check("held R", int'(R), 4);
      end
    end
    start = 1'b0;
    check("held done count", dpos.size(), 2);
    if (dpos.size() == 2) begin
      check("held done pos0", dpos[0], 8);
      check("held done pos1", dpos[1], 18);
    end
    for (int e = 0; e < 15 && busy; e++) step();
    check("held drained", int'(busy), 0);

    // Reset in the middle of CALC.
    P = 8'd200; B = 4'd7; start = 1'b1;
    step();                                   // edge k
    start = 1'b0;
    step(); step(); step(); step();           // edge k+4
    check("mid busy before reset", int'(busy), 1);
    rst_n = 1'b0;
    #1 check_zero("mid reset");
    dcount = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (done) dcount++;
    end
    check("mid reset no done", dcount, 0);
    #2 rst_n = 1'b1;
    do_op(84, 7, "post reset 84/7");

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      int rp, rb;
      rp = int'($urandom_range(0, 255));
      rb = (i % 8 == 7) ? 0 : int'($urandom_range(0, 15));
      do_op(rp, rb, $sformatf("rand %0d/%0d", rp, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
